// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame width.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV clocks while enabled.
// The count is cleared whenever the enable is low.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);
    assign o_tick = i_en && w_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_WIDTH frame per accepted start, MSB first,
// framed by SETUP/HOLD/GAP phases that each last one tick period.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    spi_state_t            r_state;
    spi_state_t            w_state_next;
    logic                  w_tick;
    logic                  w_tick_en;
    logic                  w_accept;
    logic                  w_last_fall;
    logic                  r_sclk;
    logic                  r_cs_n;
    logic                  r_done;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;

    // The done cycle is already IDLE, so acceptance is blocked for that one cycle.
    assign w_accept    = (r_state == ST_IDLE) && start && !r_done;
    assign w_tick_en   = (r_state != ST_IDLE);
    assign w_last_fall = (r_state == ST_SHIFT) && w_tick && r_sclk && (r_bit_cnt == LAST_BIT);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_next = ST_SETUP;
            ST_SETUP: if (w_tick)      w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_fall) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_tick)      w_state_next = ST_GAP;
            ST_GAP:   if (w_tick)      w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_done     <= 1'b0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tx_shift <= tx_data;
                        r_cs_n     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= !r_sclk;
                        // Rising edge samples miso; falling edge advances mosi unless it is the last bit.
                        if (!r_sclk) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], miso};
                        end else if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + BIT_ONE;
                            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_done     <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                        r_tx_shift <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE) || r_done;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_tx_shift[DATA_WIDTH-1];
    assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 32-bit/CLK_DIV=4 instance driven from a vector
// table plus hand sequences, and an 8-bit/CLK_DIV=1 instance for the fast-clock case.
module tb_spi_master;

    localparam int W_A   = 32;
    localparam int CD_A  = 4;
    localparam int LAT_A = CD_A * (2 * W_A + 3);
    localparam int W_B   = 8;
    localparam int CD_B  = 1;
    localparam int LAT_B = CD_B * (2 * W_B + 3);

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic            start_a = 1'b0;
    logic [W_A-1:0]  tx_a = '0;
    logic            busy_a, done_a, sclk_a, mosi_a, miso_a, cs_n_a;
    logic [W_A-1:0]  rx_a;
    int              mode_a = 0;

    logic            start_b = 1'b0;
    logic [W_B-1:0]  tx_b = '0;
    logic            busy_b, done_b, sclk_b, mosi_b, miso_b, cs_n_b;
    logic [W_B-1:0]  rx_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // mode 0: loopback, 1: miso tied high, 2: miso tied low
    assign miso_a = (mode_a == 0) ? mosi_a : (mode_a == 1);
    assign miso_b = mosi_b;

    spi_master #(.DATA_WIDTH(W_A), .CLK_DIV(CD_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
        .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
    );

    spi_master #(.DATA_WIDTH(W_B), .CLK_DIV(CD_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
        .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
    );

    typedef struct {
        logic [31:0] tx;
        int          mode;
        bit          poke;
        logic [31:0] exp_rx;
        bit          exp_mosi_hi;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_a(input logic [31:0] tx, input int mode, input bit poke, input bit rel,
                         output logic [31:0] rx, output int lat, output int rises,
                         output bit mosi_hi, output int viol, output bit acc, output bit held);
        logic ps, pm;
        bit   dn;
        @(negedge clk);
        if (rel) reset_n = 1'b1;
        tx_a = tx;
        mode_a = mode;
        start_a = 1'b1;
        @(posedge clk); #1;
        acc = busy_a;
        start_a = 1'b0;
        tx_a = ~tx;
        lat = 0; rises = 0; viol = 0; dn = 1'b0;
        mosi_hi = !cs_n_a && mosi_a;
        ps = sclk_a; pm = mosi_a;
        while (!dn && lat < 400) begin
            if (poke) begin
                start_a = (lat == 49);
                if (lat == 49) tx_a = 32'h12345678;
            end
            @(posedge clk); #1;
            lat++;
            if (!ps && sclk_a) rises++;
            if (ps && sclk_a && (mosi_a != pm)) viol++;
            if (!cs_n_a && mosi_a) mosi_hi = 1'b1;
            ps = sclk_a; pm = mosi_a;
            dn = done_a;
        end
        start_a = 1'b0;
        rx = rx_a;
        @(posedge clk); #1;
        held = !done_a && (rx_a == rx) && !busy_a;
    endtask

    initial begin
        logic [31:0] rx;
        int          lat, rises, viol;
        bit          mosi_hi, acc, held;

        vecs[0] = '{32'hA5C30F01, 0, 1'b0, 32'hA5C30F01, 1'b1};
        vecs[1] = '{32'h00000000, 1, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 2, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'hA5C30F01, 0, 1'b1, 32'hA5C30F01, 1'b1};
        vecs[4] = '{32'h80000001, 0, 1'b0, 32'h80000001, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rx",   rx_a,   0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i].tx, vecs[i].mode, vecs[i].poke, 1'b0, rx, lat, rises, mosi_hi, viol, acc, held);
            $display("frame %0d tx=0x%08h mode=%0d poke=%0d rx=0x%08h lat=%0d rises=%0d",
                     i, vecs[i].tx, vecs[i].mode, vecs[i].poke, rx, lat, rises);
            chk($sformatf("v%0d_accept", i), acc, 1);
            chk($sformatf("v%0d_rx", i), rx, vecs[i].exp_rx);
            chk($sformatf("v%0d_latency", i), lat, LAT_A);
            chk($sformatf("v%0d_rises", i), rises, W_A);
            chk($sformatf("v%0d_mosi_hi", i), mosi_hi, vecs[i].exp_mosi_hi);
            chk($sformatf("v%0d_mosi_stable", i), viol, 0);
            chk($sformatf("v%0d_done_pulse_held", i), held, 1);
        end

        begin : back_to_back
            int cyc, dones, hi_run, min_gap;
            bit seen_low, prev_cs, prev_done, busy_after;
            logic [31:0] rx1, rx2;
            @(negedge clk);
            tx_a = 32'hC0FFEE11; mode_a = 0; start_a = 1'b1;
            cyc = 0; dones = 0; hi_run = 0; min_gap = 1000;
            seen_low = 1'b0; prev_cs = 1'b1; prev_done = 1'b0; busy_after = 1'b1;
            rx1 = '0; rx2 = '0;
            while (dones < 2 && cyc < 1000) begin
                @(posedge clk); #1;
                cyc++;
                if (prev_done && dones == 1) busy_after = busy_a;
                if (cs_n_a) hi_run++;
                else begin
                    if (seen_low && prev_cs && hi_run < min_gap) min_gap = hi_run;
                    hi_run = 0;
                    seen_low = 1'b1;
                end
                prev_cs = cs_n_a;
                if (done_a) begin
                    dones++;
                    if (dones == 1) rx1 = rx_a; else rx2 = rx_a;
                end
                prev_done = done_a;
            end
            start_a = 1'b0;
            $display("b2b dones=%0d rx1=0x%08h rx2=0x%08h min_gap=%0d", dones, rx1, rx2, min_gap);
            chk("b2b_dones", dones, 2);
            chk("b2b_rx1", rx1, 32'hC0FFEE11);
            chk("b2b_rx2", rx2, 32'hC0FFEE11);
            chk("b2b_idle_after_done", busy_after, 0);
            chk("b2b_gap_ge_min", (min_gap >= CD_A + 1) && (min_gap < 1000), 1);
            repeat (3) @(posedge clk);
            #1;
            chk("b2b_no_third", busy_a, 0);
        end

        begin : reset_mid
            bit saw_done;
            @(negedge clk);
            tx_a = 32'hA5C30F01; mode_a = 0; start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            repeat (69) @(posedge clk);
            #3;
            reset_n = 1'b0;
            #1;
            $display("reset mid-frame cs_n=%0b sclk=%0b busy=%0b", cs_n_a, sclk_a, busy_a);
            chk("rmid_cs_n", cs_n_a, 1);
            chk("rmid_sclk", sclk_a, 0);
            chk("rmid_busy", busy_a, 0);
            chk("rmid_rx",   rx_a,   0);
            saw_done = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (done_a) saw_done = 1'b1;
            end
            chk("rmid_no_done", saw_done, 0);
            run_a(32'h3C5AA5C3, 0, 1'b0, 1'b1, rx, lat, rises, mosi_hi, viol, acc, held);
            $display("frame post-reset tx=0x3c5aa5c3 rx=0x%08h lat=%0d", rx, lat);
            chk("rmid_accept_first_edge", acc, 1);
            chk("rmid_next_rx", rx, 32'h3C5AA5C3);
            chk("rmid_next_latency", lat, LAT_A);
        end

        begin : fast_clk
            int   latb, risesb;
            logic ps;
            bit   dn;
            @(negedge clk);
            tx_b = 8'h81; start_b = 1'b1;
            @(posedge clk); #1;
            chk("b_accept", busy_b, 1);
            start_b = 1'b0; tx_b = 8'h00;
            latb = 0; risesb = 0; ps = sclk_b; dn = 1'b0;
            while (!dn && latb < 100) begin
                @(posedge clk); #1;
                latb++;
                if (!ps && sclk_b) risesb++;
                ps = sclk_b;
                dn = done_b;
            end
            $display("frame B tx=0x81 rx=0x%02h lat=%0d rises=%0d", rx_b, latb, risesb);
            chk("b_rx", rx_b, 8'h81);
            chk("b_latency", latb, LAT_B);
            chk("b_rises", risesb, W_B);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
